// File: rtl/aes_round_scheduler.sv
// AES round scheduler: arbitrates encrypt/decrypt requesters onto one shared
// round datapath and sequences round-key indices, load/last strobes and the
// done pulses for each job.
module aes_round_scheduler #(
  parameter int NK = 8,
  parameter int NR = NK + 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_req,
  input  logic       dec_req,
  input  logic       hold,
  output logic       enc_gnt,
  output logic       dec_gnt,
  output logic       busy,
  output logic       mode,
  output logic [3:0] round_idx,
  output logic       load,
  output logic       last,
  output logic       enc_done,
  output logic       dec_done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Index of the final round key and of the last ROUND cycle for encrypt.
  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] LAST_ENC = 4'(NR - 1);

  state_t     state_r, state_s;
  logic [3:0] idx_r, idx_s, step_s;
  logic       mode_r, mode_s;
  logic       last_served_r, last_served_s;   // 0 = encrypt, 1 = decrypt
  logic       grant_s;

  logic       enc_gnt_s, dec_gnt_s, busy_s, load_s, last_s, enc_done_s, dec_done_s;
  logic       enc_gnt_r, dec_gnt_r, busy_r, load_r, last_r, enc_done_r, dec_done_r;

  // Sequencing state: FSM state, round index, latched mode and arbitration history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      idx_r         <= 4'd0;
      mode_r        <= 1'b0;
      last_served_r <= 1'b1;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      mode_r        <= mode_s;
      last_served_r <= last_served_s;
    end
  end

  // Next state, next round index and round-robin arbitration.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    mode_s        = mode_r;
    last_served_s = last_served_r;
    grant_s       = 1'b0;
    // Encrypt walks the key schedule upwards, decrypt walks it downwards.
    if (mode_r) begin
      step_s = idx_r - 4'd1;
    end else begin
      step_s = idx_r + 4'd1;
    end
    case (state_r)
      ST_IDLE: begin
        idx_s = 4'd0;
        if (enc_req || dec_req) begin
          grant_s = 1'b1;
          if (enc_req && dec_req) begin
            mode_s = ~last_served_r;
          end else if (dec_req) begin
            mode_s = 1'b1;
          end else begin
            mode_s = 1'b0;
          end
          last_served_s = mode_s;
          state_s       = ST_LOAD;
          if (mode_s) begin
            idx_s = NR_IDX;
          end else begin
            idx_s = 4'd0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (hold) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_ROUND;
          idx_s   = step_s;
        end
      end
      ST_ROUND: begin
        if (hold) begin
          state_s = ST_ROUND;
        end else begin
          idx_s = step_s;
          if (idx_r == (mode_r ? 4'd1 : LAST_ENC)) begin
            state_s = ST_FINAL;
          end else begin
            state_s = ST_ROUND;
          end
        end
      end
      ST_FINAL: begin
        if (hold) begin
          state_s = ST_FINAL;
        end else begin
          state_s = ST_DONE;
          idx_s   = 4'd0;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        idx_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 4'd0;
      end
    endcase
  end

  // Output decode from the upcoming state so every strobe leaves a flop.
  always_comb begin
    enc_gnt_s  = grant_s & ~mode_s;
    dec_gnt_s  = grant_s & mode_s;
    busy_s     = 1'b0;
    load_s     = 1'b0;
    last_s     = 1'b0;
    enc_done_s = 1'b0;
    dec_done_s = 1'b0;
    case (state_s)
      ST_LOAD: begin
        busy_s = 1'b1;
        load_s = 1'b1;
      end
      ST_ROUND: begin
        busy_s = 1'b1;
      end
      ST_FINAL: begin
        busy_s = 1'b1;
        last_s = 1'b1;
      end
      ST_DONE: begin
        enc_done_s = ~mode_s;
        dec_done_s = mode_s;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // Output register for the datapath and requester strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_gnt_r  <= 1'b0;
      dec_gnt_r  <= 1'b0;
      busy_r     <= 1'b0;
      load_r     <= 1'b0;
      last_r     <= 1'b0;
      enc_done_r <= 1'b0;
      dec_done_r <= 1'b0;
    end else begin
      enc_gnt_r  <= enc_gnt_s;
      dec_gnt_r  <= dec_gnt_s;
      busy_r     <= busy_s;
      load_r     <= load_s;
      last_r     <= last_s;
      enc_done_r <= enc_done_s;
      dec_done_r <= dec_done_s;
    end
  end

  assign enc_gnt   = enc_gnt_r;
  assign dec_gnt   = dec_gnt_r;
  assign busy      = busy_r;
  assign mode      = mode_r;
  assign round_idx = idx_r;
  assign load      = load_r;
  assign last      = last_r;
  assign enc_done  = enc_done_r;
  assign dec_done  = dec_done_r;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: job-progress reference model compared every
// cycle, directed latency/arbitration/hold/reset scenarios, an NK=4 build and
// a randomized request/hold/reset phase.
module tb_aes_round_scheduler;
  localparam int NR = 14;

  logic       clk = 1'b0;
  logic       rst, enc_req, dec_req, hold;
  logic       enc_gnt, dec_gnt, busy, mode, load, last, enc_done, dec_done;
  logic [3:0] round_idx;

  logic       e4, hold4;
  logic       g4e, g4d, busy4, mode4, load4, last4, done4e, done4d;
  logic [3:0] idx4;

  aes_round_scheduler #(.NK(8)) u_dut (
    .clk(clk), .rst(rst), .enc_req(enc_req), .dec_req(dec_req), .hold(hold),
    .enc_gnt(enc_gnt), .dec_gnt(dec_gnt), .busy(busy), .mode(mode),
    .round_idx(round_idx), .load(load), .last(last),
    .enc_done(enc_done), .dec_done(dec_done));

  aes_round_scheduler #(.NK(4)) u_nk4 (
    .clk(clk), .rst(rst), .enc_req(e4), .dec_req(1'b0), .hold(hold4),
    .enc_gnt(g4e), .dec_gnt(g4d), .busy(busy4), .mode(mode4),
    .round_idx(idx4), .load(load4), .last(last4),
    .enc_done(done4e), .dec_done(done4d));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a job is NR+1 busy steps, each consumed by a non-held
  // cycle, followed by one done cycle.
  bit m_busy = 1'b0, m_done = 1'b0, m_mode = 1'b0, m_ls = 1'b1, m_gnt = 1'b0;
  int m_step = 0;
  bit chk_en = 1'b0;

  int glog_cyc[$];
  bit glog_dec[$];
  int last_cyc  = -1;
  int done_cnt  = 0;

  function automatic void check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void model_update(bit r, bit e, bit d, bit h);
    m_gnt = 1'b0;
    if (r) begin
      m_busy = 1'b0; m_done = 1'b0; m_ls = 1'b1; m_mode = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      if (!h) begin
        if (m_step == NR) begin
          m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_step++;
        end
      end
    end else if (e || d) begin
      m_mode = (e && d) ? ~m_ls : d;
      m_ls   = m_mode;
      m_busy = 1'b1;
      m_step = 0;
      m_gnt  = 1'b1;
    end
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(m_busy));
      check("enc_gnt", int'(enc_gnt), int'(m_gnt && !m_mode));
      check("dec_gnt", int'(dec_gnt), int'(m_gnt && m_mode));
      check("load", int'(load), int'(m_busy && m_step == 0));
      check("last", int'(last), int'(m_busy && m_step == NR));
      check("round_idx", int'(round_idx), m_busy ? (m_mode ? NR - m_step : m_step) : 0);
      check("enc_done", int'(enc_done), int'(m_done && !m_mode));
      check("dec_done", int'(dec_done), int'(m_done && m_mode));
      if (m_busy) check("mode", int'(mode), int'(m_mode));
    end
  end

  task automatic step_cycle(input bit r, input bit e, input bit d, input bit h);
    rst = r; enc_req = e; dec_req = d; hold = h;
    @(posedge clk);
    cyc++;
    model_update(r, e, d, h);
    @(negedge clk);
    #1;
    if (enc_gnt || dec_gnt) begin
      glog_cyc.push_back(cyc);
      glog_dec.push_back(dec_gnt);
    end
    if (last) last_cyc = cyc;
    if (enc_done || dec_done) done_cnt++;
  endtask

  task automatic do_reset();
    step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Runs one job; requests drop after grant, hold is applied when round_idx
  // first shows hold_idx. Returns grant/done cycles, index at grant, and how
  // many cycles round_idx showed hold_idx while busy.
  task automatic run_job(input bit e, input bit d, input int hold_idx, input int hold_len,
                         output int g, output int dn, output int gi, output int ncnt);
    int  hcnt = 0;
    bit  granted = 1'b0;
    g = -1; dn = -1; gi = -1; ncnt = 0;
    for (int n = 0; n < 60 && dn < 0; n++) begin
      bit h;
      h = 1'b0;
      if (granted && int'(round_idx) == hold_idx && hcnt < hold_len) begin
        h = 1'b1;
        hcnt++;
      end
      step_cycle(1'b0, e && !granted, d && !granted, h);
      if ((enc_gnt || dec_gnt) && !granted) begin
        granted = 1'b1; g = cyc; gi = int'(round_idx);
      end
      if (busy && int'(round_idx) == hold_idx) ncnt++;
      if (granted && (enc_done || dec_done)) dn = cyc;
    end
    if (dn < 0) check("job_timeout", 0, 1);
  endtask

  initial begin
    int g, dn, gi, nc, rc, k, d0;
    bit pe, pd, r, h;
    rst = 1'b1; enc_req = 1'b0; dec_req = 1'b0; hold = 1'b0;
    e4 = 1'b0; hold4 = 1'b0;

    // Reset state.
    do_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_idx", int'(round_idx), 0);
    check("rst_gnt", int'(enc_gnt | dec_gnt), 0);

    // Encrypt alone.
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 1'b0, -1, 0, g, dn, gi, nc);
    check("enc_idx_at_gnt", gi, 0);
    check("enc_last_at", last_cyc - g, 14);
    check("enc_done_at", dn - g, 15);

    // Decrypt alone.
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b0, 1'b1, -1, 0, g, dn, gi, nc);
    check("dec_idx_at_gnt", gi, 14);
    check("dec_done_at", dn - g, 15);

    // Hold for three cycles while round_idx is 5.
    step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1'b1, 1'b0, 5, 3, g, dn, gi, nc);
    check("hold_idx5_cycles", nc, 4);
    check("hold_done_at", dn - g, 18);

    // Both requests held from reset: enc, dec, enc, 17 cycles apart.
    do_reset();
    glog_cyc.delete(); glog_dec.delete();
    for (int n = 0; n < 45; n++) step_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("rr_grants", glog_cyc.size() >= 3 ? 1 : 0, 1);
    if (glog_cyc.size() >= 3) begin
      check("rr_first_enc", int'(glog_dec[0]), 0);
      check("rr_second_dec", int'(glog_dec[1]), 1);
      check("rr_third_enc", int'(glog_dec[2]), 0);
      check("rr_gap1", glog_cyc[1] - glog_cyc[0], 17);
      check("rr_gap2", glog_cyc[2] - glog_cyc[1], 17);
    end

    // Reset at round_idx 7, encrypt request still held.
    do_reset();
    k = 0;
    while (!(busy && round_idx == 4'd7) && k < 30) begin
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      k++;
    end
    check("rst_mid_reach7", int'(busy && round_idx == 4'd7), 1);
    d0 = done_cnt;
    step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    rc = cyc;
    check("rst_mid_busy", int'(busy), 0);
    g = -1;
    for (int n = 0; n < 5 && g < 0; n++) begin
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (enc_gnt) g = cyc;
    end
    check("rst_mid_regrant", g - rc, 1);
    check("rst_mid_no_done", done_cnt - d0, 0);
    for (int n = 0; n < 20; n++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // NK=4 build, encrypt alone: round_idx 0..10, done 11 cycles after grant.
    g = -1; dn = -1; k = 0;
    e4 = 1'b1;
    for (int n = 0; n < 40 && dn < 0; n++) begin
      step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (g4e) begin g = cyc; e4 = 1'b0; end
      if (busy4) begin
        check("nk4_idx", int'(idx4), k);
        k++;
      end
      if (done4e) dn = cyc;
    end
    e4 = 1'b0;
    check("nk4_busy_cycles", k, 11);
    check("nk4_done_at", dn - g, 11);

    // Randomized requests, holds and occasional resets.
    pe = 1'b0; pd = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!pe && $urandom_range(9, 0) == 0) pe = 1'b1;
      if (!pd && $urandom_range(9, 0) == 0) pd = 1'b1;
      r = ($urandom_range(199, 0) == 0);
      h = ($urandom_range(5, 0) == 0);
      step_cycle(r, pe, pd, h);
      if (m_gnt) begin
        if (m_mode) pd = 1'b0;
        else        pe = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_round_scheduler.md
AES_ROUND_SCHEDULER -- requirements
Module: aes_round_scheduler

Interface
REQ-001 The block SHALL have parameter NK, default 8, meaning the key length in 32-bit words; only 4, 6 and 8 are supported.
REQ-002 The block SHALL have parameter NR, default 14, meaning the round count; NR SHALL equal NK+6.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 enc_req  in  1  encrypt requester wants the shared round datapath; the requester holds it high until granted.
REQ-006 dec_req  in  1  decrypt requester; same hold rule as enc_req.
REQ-007 hold  in  1  datapath stall; freezes sequencing while a job runs.
REQ-008 enc_gnt  out  1  one-cycle pulse: encrypt job accepted.
REQ-009 dec_gnt  out  1  one-cycle pulse: decrypt job accepted.
REQ-010 busy  out  1  high while a job occupies the datapath.
REQ-011 mode  out  1  0 = encrypt, 1 = decrypt; valid while busy.
REQ-012 round_idx  out  4  round-key index driven to the datapath.
REQ-013 load  out  1  high in the initial AddRoundKey cycle.
REQ-014 last  out  1  high in the final round cycle (no MixColumns).
REQ-015 enc_done  out  1  one-cycle pulse: encrypt result valid.
REQ-016 dec_done  out  1  one-cycle pulse: decrypt result valid.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, ROUND, FINAL and DONE, encoded in one state register.
REQ-018 IDLE: if either request is high at the edge, the next state SHALL be LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin using a last_served bit:
- both requests high: the requester not last served wins;
- single request: that requester wins;
- last_served SHALL update on each grant.
REQ-020 The matching gnt SHALL pulse for exactly the LOAD cycle of the job; mode SHALL be latched at the IDLE->LOAD transition.
REQ-021 round_idx sequence for encrypt: LOAD = 0, ROUND = 1..NR-1 ascending, FINAL = NR.
REQ-022 round_idx sequence for decrypt: LOAD = NR, ROUND = NR-1..1 descending, FINAL = 0.
REQ-023 Transitions: LOAD->ROUND; ROUND->FINAL when the ROUND cycle with index NR-1 (encrypt) or 1 (decrypt) completes; FINAL->DONE; DONE->IDLE unconditionally.
REQ-024 hold high in LOAD, ROUND or FINAL SHALL freeze state and round_idx; hold SHALL be ignored in IDLE and DONE.
REQ-025 load SHALL be high only in LOAD; last SHALL be high only in FINAL; busy SHALL be high in LOAD, ROUND and FINAL.
REQ-026 The matching done SHALL pulse for exactly the DONE cycle; busy SHALL be low in DONE.
REQ-027 Latency without hold: done SHALL assert NR+1 cycles after gnt; each hold cycle SHALL add one cycle.
REQ-028 Back-to-back jobs SHALL have a minimum gap of one IDLE cycle between done and the next gnt.
REQ-029 A request arriving while busy SHALL wait; the scheduler SHALL never drop a held request.
REQ-030 round_idx SHALL be 0 and load/last SHALL be low in IDLE and DONE.

Reset
REQ-031 rst high at an edge SHALL force:
- state = IDLE, last_served = dec (so encrypt wins the first tie);
- round_idx = 0;
- all other outputs = 0.
REQ-032 rst mid-job SHALL abort the job: no done pulse is generated; a still-held request is regranted after rst deasserts.
REQ-033 rst SHALL take priority over hold and over all requests.

Verification (NK=8, NR=14)
REQ-034 enc_req only -> enc_gnt at cycle t, round_idx 0,1..13,14, last at t+14, enc_done at t+15, mode=0.
REQ-035 dec_req only -> round_idx 14,13..1,0, load at t, dec_done at t+15, mode=1.
REQ-036 Both requests held continuously from reset -> grants in order enc, dec, enc, with each gnt 17 cycles after the previous gnt.
REQ-037 hold high for 3 cycles while round_idx=5 -> round_idx stays 5 for 4 cycles total; done at t+18.
REQ-038 rst pulsed while round_idx=7 -> next cycle IDLE, busy=0, no done; the held request is regranted one cycle after rst deasserts.
REQ-039 NK=4 build, enc_req -> round_idx 0..10, enc_done at t+11.
